// File: rtl/aes_pkg.sv
// AES-128 shared helpers: S-boxes, GF(2^8) arithmetic, Rcon, state ops.
// FSM state encoding for aes_decrypt_core (EXPAND used with AES_DEC_KEY_EXPAND_EN).
package aes_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE,
    S_EXPAND
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                     input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[3'(i)]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; 0 maps to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]}
                ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // byte i of the state: column i/4, row i%4, byte 0 in the MSBs
  function automatic logic [7:0] get_byte(input logic [127:0] s,
                                          input int i);
    return 8'(s >> (8 * (15 - i)));
  endfunction

  function automatic logic [127:0] put_byte(input logic [7:0] v,
                                            input int i);
    return {120'b0, v} << (8 * (15 - i));
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o = o | put_byte(get_byte(s, 4 * c + r),
                         4 * ((c + r) % 4) + r);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o = o | put_byte(inv_sbox(get_byte(s, i)), i);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(s, 4 * c);
      a1 = get_byte(s, 4 * c + 1);
      a2 = get_byte(s, 4 * c + 2);
      a3 = get_byte(s, 4 * c + 3);
      o = o
        | put_byte(gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                 ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09), 4 * c)
        | put_byte(gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                 ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d), 4 * c + 1)
        | put_byte(gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                 ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b), 4 * c + 2)
        | put_byte(gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                 ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e), 4 * c + 3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_decrypt_core_key.sv
// Round-key steps: backward (k[r] -> k[r-1]) and, with
// AES_DEC_KEY_EXPAND_EN, forward (k[r-1] -> k[r]).
module inv_key_generation
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [3:0]   rnd_i,
  output logic [127:0] key_o
);
  logic [31:0] w0, w1, w2, w3, n3;

  assign {w0, w1, w2, w3} = key_i;
  assign n3 = w3 ^ w2;
  assign key_o = {w0 ^ sub_word(rot_word(n3)) ^ {rcon(rnd_i), 24'h0},
                  w1 ^ w0, w2 ^ w1, n3};
endmodule

`ifdef AES_DEC_KEY_EXPAND_EN
module key_generation
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [3:0]   rnd_i,
  output logic [127:0] key_o
);
  logic [31:0] w0, w1, w2, w3, n0, n1, n2;

  assign {w0, w1, w2, w3} = key_i;
  assign n0 = w0 ^ sub_word(rot_word(w3)) ^ {rcon(rnd_i), 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign key_o = {n0, n1, n2, w3 ^ n2};
endmodule
`endif

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher, one inverse round per clock.
// Define AES_DEC_KEY_EXPAND_EN to accept the cipher key and expand to k10 first.
module aes_decrypt_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt_out,
  output logic         busy
);
  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] data_q, data_d;
  logic [127:0] key_q, key_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] nk;
  logic [127:0] t;

  inv_key_generation u_inv_key (
    .key_i (key_q),
    .rnd_i (rnd_q),
    .key_o (nk)
  );

`ifdef AES_DEC_KEY_EXPAND_EN
  logic [127:0] fk;

  key_generation u_key (
    .key_i (key_q),
    .rnd_i (rnd_q),
    .key_o (fk)
  );
`endif

  assign t = inv_sub_bytes(inv_shift_rows(data_q)) ^ nk;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign pt_out    = pt_q;

  // Next-state and datapath update; pt only changes on completion
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    data_d  = data_q;
    key_d   = key_q;
    pt_d    = pt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          key_d = key_in;
`ifdef AES_DEC_KEY_EXPAND_EN
          data_d  = ct_in;
          rnd_d   = 4'd1;
          state_d = S_EXPAND;
`else
          data_d  = ct_in ^ key_in;
          rnd_d   = 4'd10;
          state_d = S_ROUND;
`endif
        end
      end
`ifdef AES_DEC_KEY_EXPAND_EN
      S_EXPAND: begin
        key_d = fk;
        if (rnd_q == 4'd10) begin
          data_d  = data_q ^ fk;
          state_d = S_ROUND;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
`endif
      S_ROUND: begin
        key_d = nk;
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) begin
          data_d  = t;
          pt_d    = t;
          state_d = S_DONE;
        end else begin
          data_d = inv_mix_columns(t);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      data_q  <= '0;
      key_q   <= '0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      data_q  <= data_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
    end
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed bench for aes_decrypt_core using FIPS-197 vectors.
// Honours AES_DEC_KEY_EXPAND_EN for key choice and latency.
module tb_aes_decrypt_core;
  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct_in;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt_out;
  logic         busy;

  localparam logic [127:0] B_CT = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_PT = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_DEC_KEY_EXPAND_EN
  localparam logic [127:0] B_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam int LAT = 20;
`else
  localparam logic [127:0] B_K = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C_K = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam int LAT = 10;
`endif

  int n_pass = 0;
  int n_chk  = 0;

  aes_decrypt_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct_in     (ct_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt_out    (pt_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [127:0] ct, input logic [127:0] k);
    ct_in    = ct;
    key_in   = k;
    in_valid = 1'b1;
    check("in_ready_idle", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    check("busy_after_accept", 128'(busy), 128'(1));
    check("in_ready_after_accept", 128'(in_ready), 128'(0));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    check(tag, 128'(n), 128'(LAT));
  endtask

  logic [127:0] got [2];
  int           acc [2];
  int           acc_n;
  int           out_n;
  logic         took;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ct_in     = '0;
    key_in    = '0;
    step();
    step();
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_pt_out", pt_out, '0);
    rst_n = 1'b1;
    step();

    // App. B with output taken immediately
    out_ready = 1'b1;
    start(B_CT, B_K);
    wait_done("appb_latency");
    check("appb_pt", pt_out, B_PT);
    step();
    check("appb_out_valid_drop", 128'(out_valid), 128'(0));
    check("appb_in_ready_back", 128'(in_ready), 128'(1));
    check("appb_pt_held", pt_out, B_PT);

    // C.1
    start(C_CT, C_K);
    wait_done("c1_latency");
    check("c1_pt", pt_out, C_PT);
    step();

    // Backpressure: new input offered while output is stalled
    out_ready = 1'b0;
    start(B_CT, B_K);
    wait_done("bp_latency");
    ct_in    = C_CT;
    key_in   = C_K;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_pt_stable", pt_out, B_PT);
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    step();
    check("bp_hs_in_ready", 128'(in_ready), 128'(1));
    check("bp_hs_out_valid", 128'(out_valid), 128'(0));
    step();
    in_valid = 1'b0;
    check("bp_new_accept", 128'(busy), 128'(1));
    wait_done("bp_new_latency");
    check("bp_new_pt", pt_out, C_PT);
    step();

    // Reset mid-run
    start(B_CT, B_K);
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 128'(in_ready), 128'(1));
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_pt_out", pt_out, '0);
    step();
    rst_n = 1'b1;
    step();
    start(B_CT, B_K);
    wait_done("rerun_latency");
    check("rerun_pt", pt_out, B_PT);
    step();

    // Back-to-back with in_valid held high
    acc_n    = 0;
    out_n    = 0;
    ct_in    = B_CT;
    key_in   = B_K;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && out_n < 2; i++) begin
      took = in_valid && in_ready;
      if (out_valid && out_n < 2) begin
        got[out_n] = pt_out;
        out_n++;
      end
      step();
      if (took && acc_n < 2) begin
        acc[acc_n] = i;
        acc_n++;
        ct_in  = C_CT;
        key_in = C_K;
        if (acc_n == 2) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("b2b_outputs", 128'(out_n), 128'(2));
    check("b2b_accepts", 128'(acc_n), 128'(2));
    if (out_n == 2 && acc_n == 2) begin
      check("b2b_pt0", got[0], B_PT);
      check("b2b_pt1", got[1], C_PT);
      check("b2b_spacing", 128'(acc[1] - acc[0]), 128'(LAT + 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
